dmem_confreg_responder: RTL
===========================

Name: dmem_confreg_responder

Overview:
Responder end of the miniCPU data_sram interface. It decodes every data_sram access and steers it to one of two targets:
- a word-addressed data RAM, with combinational read and synchronous write;
- a small bank of memory-mapped config registers: LED, switches, a free-running timer with compare, and a scratch word.

Read data must be valid in the same cycle as the address, because the core samples data_sram_rdata combinationally for ld.w. The block sits beside the core at SoC top level.

Parameters:
RAM_AW, 10, RAM word-address width (depth = 2^RAM_AW words)
RAM_BASE, 32'h1c80_0000, byte base of RAM window (aligned to 2^(RAM_AW+2))
CONF_BASE, 32'h1faf_0000, byte base of 64 KB config window

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_sram_we  in  1  write strobe (word write)
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  read data, combinational from addr
switch_in  in  16  asynchronous board switches
led_out  out  16  LED register value
timer_irq  out  1  STATUS.match & CTRL.irq_en

Behaviour:
- Clocking: clk with reset (synchronous, active-high). All state updates on posedge clk.
- Decode:
  - ram_hit = addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2].
  - conf_hit = addr[31:16] == CONF_BASE[31:16].
  - Anything else is unmapped: reads return 0, writes are ignored.
  - addr[1:0] is ignored everywhere; all accesses are full words.
- RAM:
  - Index is addr[RAM_AW+1:2].
  - Write on posedge when we & ram_hit.
  - Read is combinational: a read of the word written in the previous cycle returns the new value.
  - Contents are not affected by reset.
- Config registers, at offset addr[15:0]; other offsets read 0 and ignore writes:
  - 0x0000 LED: RW, bits[15:0]; upper bits read 0. Reset 0. Drives led_out directly.
  - 0x0004 SWITCH: RO. Value is switch_in through a 2-flop synchronizer, so a pin change is visible on the 2nd posedge after it. Reset 0.
  - 0x0008 TIMER: RW, 32 bits.
    - When CTRL.en=1, increments by 1 each cycle and wraps 0xFFFF_FFFF -> 0.
    - A write loads wdata, and the write wins over the increment that cycle.
    - Reset 0.
  - 0x000C CMP: RW, 32 bits. Reset 0xFFFF_FFFF.
  - 0x0010 CTRL: RW. bit0 en, bit1 irq_en; other bits read 0. Reset 0.
  - 0x0014 STATUS: bit0 match, sticky.
    - Set on the posedge at which next-timer-value == CMP (next value after increment or load).
    - Writing 1 to bit0 clears it; if set and clear occur in the same cycle, set wins.
    - Reset 0.
  - 0x0018 SCRATCH: RW, 32 bits. Reset 0.
- Read mux is combinational over registered state. A read in the same cycle as a write to the same register returns the old value.
- Reset asserted mid-operation: all registers return to reset values on that edge; any write presented in that cycle is discarded for config registers. RAM writes during reset are also blocked.
- Reset values of outputs: led_out=0, timer_irq=0. data_sram_rdata is a pure function of addr and state.

Decomposition:
- Shared package dmem_pkg holds:
  - config offset constants: OFS_LED, OFS_SW, OFS_TIMER, OFS_CMP, OFS_CTRL, OFS_STATUS, OFS_SCRATCH;
  - CTRL bit indices;
  - default base addresses.
- One sub-module, dmem_ram: parameterized distributed RAM with async read and sync write.
- Decode, config registers, timer and synchronizer stay in the top.

Test Plan:
- RAM write/read: write 0x1c80_0010 <= 0xDEAD_BEEF, next cycle read 0x1c80_0010 -> 0xDEAD_BEEF. Read 0x1c80_0013 -> same word. Read 0x1c80_0014 -> previously written or unchanged contents.
- Unmapped: write 0x0000_1000 <= 5, read it -> 0. No RAM or register changes.
- LED/SCRATCH: write LED <= 0xFFFF_1234 -> led_out = 0x1234 next cycle, read LED = 0x0000_1234. SCRATCH round-trips 0xA5A5_5A5A. Reset mid-sequence -> led_out = 0, SCRATCH = 0.
- Timer/compare: CMP <= 10, CTRL <= 3, TIMER <= 0. STATUS.match and timer_irq rise on the 10th posedge after the load. W1C STATUS clears it. Write TIMER <= 0xFFFF_FFFF with en=1 -> next value 0.
- Set/clear collision: arrange next-timer == CMP on the same cycle as a STATUS write of 1 -> match stays 1.
- Switch sync: change switch_in 0x0000 -> 0x00F0. A read of SWITCH returns 0 after 1 edge and 0x0000_00F0 after 2 edges.

Source files
------------

// File: rtl/dmem_confreg_responder_pkg.sv
// dmem_pkg: shared constants for the data_sram responder.
//   - default window bases and RAM address width
//   - config register offsets within the 64 KB config window
//   - CTRL / STATUS bit indices
package dmem_pkg;

    localparam int          RAM_AW_DEF    = 10;
    localparam logic [31:0] RAM_BASE_DEF  = 32'h1c80_0000;
    localparam logic [31:0] CONF_BASE_DEF = 32'h1faf_0000;

    localparam logic [15:0] OFS_LED     = 16'h0000;
    localparam logic [15:0] OFS_SW      = 16'h0004;
    localparam logic [15:0] OFS_TIMER   = 16'h0008;
    localparam logic [15:0] OFS_CMP     = 16'h000C;
    localparam logic [15:0] OFS_CTRL    = 16'h0010;
    localparam logic [15:0] OFS_STATUS  = 16'h0014;
    localparam logic [15:0] OFS_SCRATCH = 16'h0018;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/dmem_confreg_responder_if.sv
// dmem_confreg_responder_if: miniCPU data_sram bus.
//   master (core)      drives we/addr/wdata, samples rdata
//   slave  (responder) samples we/addr/wdata, drives rdata combinationally
interface dmem_confreg_responder_if;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/dmem_confreg_responder_ram.sv
// dmem_ram: word-wide distributed RAM, asynchronous read, synchronous write.
//   clk    clock
//   we     write enable (already qualified by decode and reset)
//   addr   word index
//   wdata  write data
//   rdata  read data, combinational from addr
// Contents have no reset.
module dmem_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_confreg_responder.sv
// dmem_confreg_responder: responder end of the data_sram bus.
//   clk, reset   clock, synchronous active-high reset
//   bus          data_sram slave (we/addr/wdata in, rdata out, combinational)
//   switch_in    asynchronous board switches, double-flop synchronized
//   led_out      LED register
//   timer_irq    STATUS.match & CTRL.irq_en
// Accesses are steered to the RAM window, the config window, or ignored.
module dmem_confreg_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_AW    = RAM_AW_DEF,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    dmem_confreg_responder_if.slave  bus,
    input  logic [15:0]              switch_in,
    output logic [15:0]              led_out,
    output logic                     timer_irq
);

    logic        ram_hit, conf_hit, conf_wr;
    logic [15:0] ofs;
    logic [31:0] wdata;
    logic [31:0] ram_rdata, conf_rdata;
    logic        unused_addr_bits;

    assign wdata    = bus.data_sram_wdata;
    assign ram_hit  = bus.data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
    assign conf_hit = bus.data_sram_addr[31:16] == CONF_BASE[31:16];
    assign conf_wr  = bus.data_sram_we & conf_hit;
    // Byte lane bits are dropped so every access aligns to its word.
    assign ofs      = {bus.data_sram_addr[15:2], 2'b00};
    assign unused_addr_bits = &{1'b0, bus.data_sram_addr[1:0]};

    dmem_ram #(.AW(RAM_AW), .DW(32)) u_ram (
        .clk   (clk),
        .we    (bus.data_sram_we & ram_hit & ~reset),
        .addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d, irq_en_q, irq_en_d;
    logic        match_q, match_d;
    logic [31:0] scratch_q, scratch_d;

    always_comb begin
        led_d     = led_q;
        cmp_d     = cmp_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        sw_meta_d = switch_in;
        sw_sync_d = sw_meta_q;
        timer_d   = en_q ? timer_q + 32'd1 : timer_q;
        match_d   = match_q;

        if (conf_wr) begin
            case (ofs)
                OFS_LED:     led_d     = wdata[15:0];
                OFS_TIMER:   timer_d   = wdata;
                OFS_CMP:     cmp_d     = wdata;
                OFS_CTRL: begin
                    en_d     = wdata[CTRL_EN];
                    irq_en_d = wdata[CTRL_IRQ_EN];
                end
                OFS_STATUS:  if (wdata[STATUS_MATCH]) match_d = 1'b0;
                OFS_SCRATCH: scratch_d = wdata;
                default: ;
            endcase
        end

        // Compare against the value the timer is about to take; set beats clear.
        if (timer_d == cmp_q) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            timer_q   <= '0;
            cmp_q     <= 32'hFFFF_FFFF;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            match_q   <= 1'b0;
            scratch_q <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            match_q   <= match_d;
            scratch_q <= scratch_d;
        end
    end

    always_comb begin
        conf_rdata = '0;
        case (ofs)
            OFS_LED:     conf_rdata = {16'h0, led_q};
            OFS_SW:      conf_rdata = {16'h0, sw_sync_q};
            OFS_TIMER:   conf_rdata = timer_q;
            OFS_CMP:     conf_rdata = cmp_q;
            OFS_CTRL:    conf_rdata = {30'h0, irq_en_q, en_q};
            OFS_STATUS:  conf_rdata = {31'h0, match_q};
            OFS_SCRATCH: conf_rdata = scratch_q;
            default:     conf_rdata = '0;
        endcase
    end

    assign bus.data_sram_rdata = ram_hit  ? ram_rdata  :
                                 conf_hit ? conf_rdata : 32'h0;
    assign led_out   = led_q;
    assign timer_irq = match_q & irq_en_q;

endmodule
